// File: rtl/iob_eth_mdio_phy.sv
// Clause-22 MDIO responder (PHY side): oversamples MDC in the clk_i domain,
// decodes read/write frames for PHY_ADDR and serves a small register set.

module iob_eth_mdio_phy_regs #(
   parameter logic [15:0] PHY_ID1  = 16'h0022,
   parameter logic [15:0] PHY_ID2  = 16'h1622,
   parameter logic [15:0] BMSR_VAL = 16'h7809
) (
   input  logic        clk_i,
   input  logic        cke_i,
   input  logic        arst_n_i,
   input  logic [4:0]  rd_addr_i,
   output logic [15:0] rd_data_o,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_addr_i,
   input  logic [15:0] wr_data_i,
   output logic [15:0] bmcr_o
);

   localparam logic [15:0] BMCR_RST = 16'h1140;

   logic [15:0]      bmcr_q, bmcr_d;
   logic [3:0][15:0] scr_q, scr_d;

   always_comb begin
      bmcr_d = bmcr_q;
      scr_d  = scr_q;
      if (wr_en_i) begin
         if (wr_addr_i == 5'd0) begin
            // bit 15 is a soft reset of BMCR and the scratch block, never stored
            if (wr_data_i[15]) begin
               bmcr_d = BMCR_RST;
               scr_d  = '0;
            end else begin
               bmcr_d = {1'b0, wr_data_i[14:0]};
            end
         end else if (wr_addr_i[4:2] == 3'b001) begin
            scr_d[wr_addr_i[1:0]] = wr_data_i;
         end
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (rd_addr_i[4:2] == 3'b001) begin
         rd_data_o = scr_q[rd_addr_i[1:0]];
      end else if (rd_addr_i[4:2] == 3'b000) begin
         case (rd_addr_i[1:0])
            2'd0:    rd_data_o = bmcr_q;
            2'd1:    rd_data_o = BMSR_VAL;
            2'd2:    rd_data_o = PHY_ID1;
            default: rd_data_o = PHY_ID2;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         bmcr_q <= BMCR_RST;
         scr_q  <= '0;
      end else if (cke_i) begin
         bmcr_q <= bmcr_d;
         scr_q  <= scr_d;
      end
   end

   assign bmcr_o = bmcr_q;

endmodule

// state | meaning
// IDLE  | counting preamble ones, waiting for the first ST bit (0)
// ST    | second start bit, must be 1
// OP    | two opcode bits, 10 = read, 01 = write
// PHYAD | five PHY address bits, latch match
// REGAD | five register address bits, load read data on the last one
// TA    | turnaround: drive 0 / first data bit on read, check 1,0 on write
// DATA  | sixteen data bit periods, commit write on the last one
module iob_eth_mdio_phy #(
   parameter logic [4:0]  PHY_ADDR = 5'd0,
   parameter logic [15:0] PHY_ID1  = 16'h0022,
   parameter logic [15:0] PHY_ID2  = 16'h1622,
   parameter logic [15:0] BMSR_VAL = 16'h7809
) (
   input  logic        clk_i,
   input  logic        cke_i,
   input  logic        arst_n_i,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe_o,
   output logic [15:0] bmcr_o,
   output logic        wr_strb_o,
   output logic [7:0]  frame_err_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
   } state_t;

   logic        mdc_s1_q, mdc_s2_q, mdc_prev_q;
   logic        mdio_s1_q, mdio_s2_q;
   logic        evt, bit_in;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  ones_q, ones_d;
   logic        op_rd_q, op_rd_d;
   logic [4:0]  addr_sh_q, addr_sh_d;
   logic        match_q, match_d;
   logic        ta_ok_q, ta_ok_d;
   logic [15:0] data_q, data_d;
   logic        mdio_q, mdio_d;
   logic        oe_q, oe_d;
   logic        wr_strb_q, wr_strb_d;
   logic [7:0]  err_q, err_d;
   logic        err_inc;
   logic        wr_en;
   logic [15:0] rd_data;

   assign evt    = cke_i & mdc_s2_q & ~mdc_prev_q;
   assign bit_in = mdio_s2_q;

   iob_eth_mdio_phy_regs #(
      .PHY_ID1  (PHY_ID1),
      .PHY_ID2  (PHY_ID2),
      .BMSR_VAL (BMSR_VAL)
   ) u_regs (
      .clk_i     (clk_i),
      .cke_i     (cke_i),
      .arst_n_i  (arst_n_i),
      .rd_addr_i ({addr_sh_q[3:0], bit_in}),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_addr_i (addr_sh_q),
      .wr_data_i ({data_q[14:0], bit_in}),
      .bmcr_o    (bmcr_o)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ones_d    = ones_q;
      op_rd_d   = op_rd_q;
      addr_sh_d = addr_sh_q;
      match_d   = match_q;
      ta_ok_d   = ta_ok_q;
      data_d    = data_q;
      mdio_d    = mdio_q;
      oe_d      = oe_q;
      wr_strb_d = 1'b0;
      err_inc   = 1'b0;
      wr_en     = 1'b0;

      if (evt) begin
         unique case (state_q)
            S_IDLE: begin
               if (bit_in) begin
                  if (ones_q != 6'd32) ones_d = ones_q + 6'd1;
               end else begin
                  ones_d = '0;
                  if (ones_q == 6'd32) state_d = S_ST;
               end
            end
            S_ST: begin
               if (bit_in) begin
                  state_d = S_OP;
                  cnt_d   = 4'd1;
               end else begin
                  err_inc = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_OP: begin
               if (cnt_q != 4'd0) begin
                  op_rd_d = bit_in;
                  cnt_d   = cnt_q - 4'd1;
               end else if (op_rd_q != bit_in) begin
                  // op_rd_q holds the first opcode bit: 1 means "10" (read)
                  state_d = S_PHYAD;
                  cnt_d   = 4'd4;
               end else begin
                  err_inc = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_PHYAD: begin
               addr_sh_d = {addr_sh_q[3:0], bit_in};
               cnt_d     = cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  match_d = ({addr_sh_q[3:0], bit_in} == PHY_ADDR);
                  state_d = S_REGAD;
                  cnt_d   = 4'd4;
               end
            end
            S_REGAD: begin
               addr_sh_d = {addr_sh_q[3:0], bit_in};
               cnt_d     = cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  state_d = S_TA;
                  cnt_d   = 4'd1;
                  ta_ok_d = 1'b1;
                  if (op_rd_q && match_q) data_d = rd_data;
               end
            end
            S_TA: begin
               cnt_d = cnt_q - 4'd1;
               if (op_rd_q) begin
                  if (match_q) begin
                     if (cnt_q == 4'd1) begin
                        oe_d   = 1'b1;
                        mdio_d = 1'b0;
                     end else begin
                        mdio_d = data_q[15];
                        data_d = {data_q[14:0], 1'b0};
                     end
                  end
               end else if (bit_in != cnt_q[0]) begin
                  // write turnaround must read 1 then 0
                  ta_ok_d = 1'b0;
               end
               if (cnt_q == 4'd0) begin
                  state_d = S_DATA;
                  cnt_d   = 4'd15;
               end
            end
            S_DATA: begin
               cnt_d = cnt_q - 4'd1;
               if (op_rd_q) begin
                  if (cnt_q == 4'd0) begin
                     oe_d    = 1'b0;
                     mdio_d  = 1'b0;
                     state_d = S_IDLE;
                  end else if (match_q) begin
                     mdio_d = data_q[15];
                     data_d = {data_q[14:0], 1'b0};
                  end
               end else begin
                  data_d = {data_q[14:0], bit_in};
                  if (cnt_q == 4'd0) begin
                     state_d = S_IDLE;
                     if (!ta_ok_q) begin
                        err_inc = 1'b1;
                     end else if (match_q) begin
                        wr_en     = 1'b1;
                        wr_strb_d = 1'b1;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      err_d = err_q;
      if (err_inc && (err_q != 8'hff)) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         mdc_s1_q   <= 1'b0;
         mdc_s2_q   <= 1'b0;
         mdc_prev_q <= 1'b0;
         mdio_s1_q  <= 1'b0;
         mdio_s2_q  <= 1'b0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ones_q     <= '0;
         op_rd_q    <= 1'b0;
         addr_sh_q  <= '0;
         match_q    <= 1'b0;
         ta_ok_q    <= 1'b0;
         data_q     <= '0;
         mdio_q     <= 1'b0;
         oe_q       <= 1'b0;
         wr_strb_q  <= 1'b0;
         err_q      <= '0;
      end else if (cke_i) begin
         mdc_s1_q   <= mdc_i;
         mdc_s2_q   <= mdc_s1_q;
         mdc_prev_q <= mdc_s2_q;
         mdio_s1_q  <= mdio_i;
         mdio_s2_q  <= mdio_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ones_q     <= ones_d;
         op_rd_q    <= op_rd_d;
         addr_sh_q  <= addr_sh_d;
         match_q    <= match_d;
         ta_ok_q    <= ta_ok_d;
         data_q     <= data_d;
         mdio_q     <= mdio_d;
         oe_q       <= oe_d;
         wr_strb_q  <= wr_strb_d;
         err_q      <= err_d;
      end
   end

   assign mdio_o          = mdio_q;
   assign mdio_oe_o       = oe_q;
   assign wr_strb_o       = wr_strb_q;
   assign frame_err_cnt_o = err_q;

endmodule
